ddr5_phy_crc_checker: RTL
=========================

// Module: ddr5_phy_crc_checker
// PURPOSE
//   Receive-side counterpart of the write-path CRC generator: checks DDR5 burst data against its CRC.
//   Accumulates CRC-8 (poly x^8+x^2+x+1, 0x07) per 8-bit slice over a burst of data cycles,
//   then compares the result with the CRC beat that follows.
//   Sits on the DQ capture path (read-data check / loopback CRC verification); flags mismatches per slice.
// PARAMETERS
//   pDRAM_SIZE     4   device width (4, 8, 16); bus = 2*pDRAM_SIZE bits (2 UI per clk), slices = pDRAM_SIZE/4
//   pBURST_CYCLES  8   data cycles per burst before the CRC cycle (BL16 = 8 clk); legal 1..15
// PORTS
//   clk_i           in   1              clock
//   rst_i           in   1              asynchronous reset, active low
//   chk_start_i     in   1              qualifies first data cycle of a burst (valid only with chk_valid_i)
//   chk_valid_i     in   1              data/CRC word on chk_data_i is valid this cycle
//   chk_data_i      in   2*pDRAM_SIZE   data beats, then CRC beat (slice k = bits [8k+7:8k])
//   chk_busy_o      out  1              FSM not in IDLE
//   crc_done_o      out  1              1-cycle pulse: burst check complete
//   crc_err_o       out  1              1-cycle pulse with crc_done_o: any slice mismatched
//   crc_err_lane_o  out  pDRAM_SIZE/4   per-slice mismatch, held until next crc_done_o
//   burst_abort_o   out  1              1-cycle pulse: burst restarted before its CRC cycle
//   err_cnt_o       out  16             saturating mismatch-burst counter (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst_i=0, async): FSM=IDLE, CRC accumulators=0x00, beat counter=0, all outputs 0.
//   - CRC update per slice per accepted data cycle: crc <= crc8_0x07(crc ^ slice), byte-parallel,
//     MSB first; init 0x00, no reflection, no final XOR. Same equations as the generator.
//   - FSM states:
//     IDLE: start&valid -> accumulators load crc8(0x00^slice), cnt=1; then DATA (or CRC if pBURST_CYCLES=1).
//           valid without start ignored.
//     DATA: valid -> accumulate, cnt++; when cnt reaches pBURST_CYCLES go to CRC. valid=0 -> hold (gaps legal).
//     CRC:  valid -> compare each slice of chk_data_i with its accumulator; go to IDLE.
//           valid=0 -> hold.
//   - Result latency: crc_done_o, crc_err_o and crc_err_lane_o update on the clock edge after the CRC
//     cycle is accepted (registered; 1 clk). crc_err_o = |mismatch vector.
//   - Back-to-back: start&valid in the cycle right after the CRC cycle is accepted, in IDLE;
//     zero bubble required.
//   - start&valid while in DATA or CRC: current burst discarded, burst_abort_o pulses next clk,
//     new burst begins with this word as data cycle 1; no crc_done_o for the aborted burst.
//   - chk_start_i without chk_valid_i: ignored in every state.
//   - Reset mid-burst: immediate return to IDLE, no done/abort pulse, lane flags cleared.
//   - chk_busy_o = (state != IDLE), combinational from state register.
// CONFIGURATION
//   DDR5_PHY_CRC_ERR_CNT_EN defined: err_cnt_o increments by 1 on every crc_err_o pulse,
//     saturates at 16'hFFFF, cleared only by reset.
//   Not defined: counter logic absent, err_cnt_o tied to 16'h0000.
// TESTING
//   1. pDRAM_SIZE=4, 8 data cycles 0x00, CRC beat 0x00 -> crc_done_o pulse 1 clk after CRC, crc_err_o=0.
//   2. Same burst, CRC beat 0x01 -> crc_err_o=1, crc_err_lane_o=1'b1; holds until next done.
//   3. pBURST_CYCLES=1, pDRAM_SIZE=8: data 16'h0001, CRC 16'h0007 -> no error;
//      CRC 16'h0107 -> crc_err_lane_o=2'b10.
//   4. Burst 1 (zeros) with valid gaps of 3 cycles in DATA and CRC; burst 2 starts the cycle after CRC
//      -> two done pulses, no abort; result unchanged by the gaps.
//   5. start&valid at data cycle 5 of a burst -> burst_abort_o pulse; new burst completes normally.
//   6. With DDR5_PHY_CRC_ERR_CNT_EN: 3 failing bursts -> err_cnt_o=3; assert rst_i mid-burst
//      -> all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/ddr5_phy_crc_checker.sv
// Receive-side DDR5 burst CRC-8 (poly 0x07) checker, one CRC per 8-bit slice of the DQ word.
// Optional saturating mismatch counter enabled by defining DDR5_PHY_CRC_ERR_CNT_EN.
module ddr5_phy_crc_checker #(
    parameter int pDRAM_SIZE    = 4,
    parameter int pBURST_CYCLES = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      chk_start_i,
    input  logic                      chk_valid_i,
    input  logic [2*pDRAM_SIZE-1:0]   chk_data_i,
    output logic                      chk_busy_o,
    output logic                      crc_done_o,
    output logic                      crc_err_o,
    output logic [pDRAM_SIZE/4-1:0]   crc_err_lane_o,
    output logic                      burst_abort_o,
    output logic [15:0]               err_cnt_o
);

    localparam int          NUM_SLICES = pDRAM_SIZE / 4;
    localparam logic [3:0]  BURST_LAST = 4'(pBURST_CYCLES);

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_DATA = 2'd1;
    localparam logic [1:0]  ST_CRC  = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [NUM_SLICES-1:0][7:0]  acc_q, acc_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;
    logic [NUM_SLICES-1:0]       lane_q, lane_d;
    logic                        abort_q, abort_d;
    logic [NUM_SLICES-1:0]       mismatch;
    logic                        start;

    // Byte-parallel CRC-8, MSB first, no reflection; identical to the write-path generator.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign start = chk_start_i & chk_valid_i;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lane_d   = lane_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        abort_d  = 1'b0;
        mismatch = '0;

        for (int k = 0; k < NUM_SLICES; k++) begin
            mismatch[k] = (chk_data_i[8*k +: 8] != acc_q[k]);
        end

        if (start) begin
            // A start word always opens a new burst; anything in flight is dropped.
            abort_d = (state_q != ST_IDLE);
            for (int k = 0; k < NUM_SLICES; k++) begin
                acc_d[k] = crc8_step(8'h00, chk_data_i[8*k +: 8]);
            end
            cnt_d   = 4'd1;
            state_d = (BURST_LAST == 4'd1) ? ST_CRC : ST_DATA;
        end else if (chk_valid_i) begin
            case (state_q)
                ST_DATA: begin
                    for (int k = 0; k < NUM_SLICES; k++) begin
                        acc_d[k] = crc8_step(acc_q[k], chk_data_i[8*k +: 8]);
                    end
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == BURST_LAST) begin
                        state_d = ST_CRC;
                    end
                end
                ST_CRC: begin
                    done_d  = 1'b1;
                    err_d   = |mismatch;
                    lane_d  = mismatch;
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end
                ST_IDLE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lane_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            err_q   <= err_d;
            lane_q  <= lane_d;
            abort_q <= abort_d;
        end
    end

`ifdef DDR5_PHY_CRC_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = 16'h0000;
`endif

    assign chk_busy_o     = (state_q != ST_IDLE);
    assign crc_done_o     = done_q;
    assign crc_err_o      = err_q;
    assign crc_err_lane_o = lane_q;
    assign burst_abort_o  = abort_q;

endmodule
